// File: rtl/bomb_pkg.sv
// ---------------------------------------------------------------------------
// bomb_pkg : shared state, LED, digit-sentinel and seven-segment definitions
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bomb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_DEFUSED  = 2'd2,
    ST_EXPLODED = 2'd3
  } state_e;

  localparam logic [3:0] C_LED_IDLE     = 4'b0001;
  localparam logic [3:0] C_LED_ARMED    = 4'b0010;
  localparam logic [3:0] C_LED_DEFUSED  = 4'b0100;
  localparam logic [3:0] C_LED_EXPLODED = 4'b1000;

  // Countdown drives both digits to F when it underflows past 00.
  localparam logic [3:0] C_DIGIT_SENTINEL = 4'hF;

  // Active-high segments {g,f,e,d,c,b,a}; non-decimal codes (incl. sentinel) blank.
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_det.sv
// ---------------------------------------------------------------------------
// edge_det : registered-history rise/fall detector, one bit per input line
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] prev_q;

  // Reset also captures the live input so no edge is reported right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= d_i;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;
  assign fall_o = prev_q & ~d_i;

endmodule

`default_nettype wire

// File: rtl/bomb_game_ctrl.sv
// ---------------------------------------------------------------------------
// bomb_game_ctrl : arms the countdown, judges wire cuts/expiry, drives LEDs
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bomb_game_ctrl
  import bomb_pkg::*;
#(
  parameter int            NW          = 4,
  parameter logic [NW-1:0] SAFE_MASK   = 4'b0101,
  parameter int            MAX_STRIKES = 2,
  parameter int            BLINK_DIV   = 500
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_start,
  input  logic [NW-1:0] wires,
  input  logic [3:0]    s1,
  input  logic [3:0]    s2,
  output logic          start,
  output logic          success,
  output logic [3:0]    state_led,
  output logic [1:0]    strikes,
  output logic          wire_fault,
  output logic          buzzer
);

  localparam int            BW           = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [1:0]    C_MAX_STRK   = 2'(MAX_STRIKES);
  localparam logic [NW-1:0] C_ALL_ONES   = '1;

  state_e        state_q, state_d;
  logic [1:0]    strikes_q, strikes_d;
  logic          wire_fault_q, wire_fault_d;
  logic          buzzer_q, buzzer_d;
  logic          start_q, start_d;
  logic          success_q, success_d;
  logic [3:0]    led_q, led_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [NW-1:0] safe_cut_q, safe_cut_d;

  logic          w_btn_rise;
  logic [NW-1:0] w_wire_fall;
  logic          w_expired;
  logic          w_trap_cut;
  logic          w_safe_done;
  logic [1:0]    w_strikes_inc;

  edge_det #(.W(1)) u_btn_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (btn_start),
    .rise_o (w_btn_rise),
    .fall_o ()
  );

  edge_det #(.W(NW)) u_wire_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (wires),
    .rise_o (),
    .fall_o (w_wire_fall)
  );

  assign w_expired     = (s1 == C_DIGIT_SENTINEL) && (s2 == C_DIGIT_SENTINEL);
  assign w_trap_cut    = |(w_wire_fall & ~SAFE_MASK);
  assign w_strikes_inc = (strikes_q == 2'd3) ? 2'd3 : strikes_q + 2'd1;
  // Safe cuts are remembered, so reconnecting a safe wire cannot undo progress.
  assign w_safe_done   = ((safe_cut_q | w_wire_fall) & SAFE_MASK) == SAFE_MASK;

  always_comb begin
    state_d      = state_q;
    strikes_d    = strikes_q;
    wire_fault_d = wire_fault_q;
    buzzer_d     = buzzer_q;
    blink_d      = blink_q;
    safe_cut_d   = safe_cut_q;

    unique case (state_q)
      ST_IDLE: begin
        if (w_btn_rise) begin
          if (wires == C_ALL_ONES) begin
            state_d      = ST_ARMED;
            strikes_d    = 2'd0;
            wire_fault_d = 1'b0;
            safe_cut_d   = '0;
          end else begin
            wire_fault_d = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        safe_cut_d = safe_cut_q | (w_wire_fall & SAFE_MASK);
        if (w_expired) begin
          state_d = ST_EXPLODED;
        end else if (w_trap_cut) begin
          strikes_d = w_strikes_inc;
          if (w_strikes_inc >= C_MAX_STRK) begin
            state_d = ST_EXPLODED;
          end
        end else if (w_safe_done) begin
          state_d = ST_DEFUSED;
        end
        // Alarm starts sounding immediately on explosion.
        if (state_d == ST_EXPLODED) begin
          buzzer_d = 1'b1;
          blink_d  = '0;
        end
      end
      ST_DEFUSED: begin
        buzzer_d = 1'b0;
        if (w_btn_rise) begin
          state_d = ST_IDLE;
        end
      end
      ST_EXPLODED: begin
        if (w_btn_rise) begin
          state_d  = ST_IDLE;
          buzzer_d = 1'b0;
          blink_d  = '0;
        end else if (blink_q == C_BLINK_LAST) begin
          blink_d  = '0;
          buzzer_d = ~buzzer_q;
        end else begin
          blink_d  = blink_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    start_d   = 1'b0;
    success_d = 1'b0;
    led_d     = C_LED_IDLE;
    case (state_d)
      ST_ARMED: begin
        start_d = 1'b1;
        led_d   = C_LED_ARMED;
      end
      ST_DEFUSED: begin
        start_d   = 1'b1;
        success_d = 1'b1;
        led_d     = C_LED_DEFUSED;
      end
      ST_EXPLODED: led_d = buzzer_d ? C_LED_EXPLODED : 4'b0000;
      default:     led_d = C_LED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      strikes_q    <= 2'd0;
      wire_fault_q <= 1'b0;
      buzzer_q     <= 1'b0;
      start_q      <= 1'b0;
      success_q    <= 1'b0;
      led_q        <= C_LED_IDLE;
      blink_q      <= '0;
      safe_cut_q   <= '0;
    end else begin
      state_q      <= state_d;
      strikes_q    <= strikes_d;
      wire_fault_q <= wire_fault_d;
      buzzer_q     <= buzzer_d;
      start_q      <= start_d;
      success_q    <= success_d;
      led_q        <= led_d;
      blink_q      <= blink_d;
      safe_cut_q   <= safe_cut_d;
    end
  end

  assign start      = start_q;
  assign success    = success_q;
  assign state_led  = led_q;
  assign strikes    = strikes_q;
  assign wire_fault = wire_fault_q;
  assign buzzer     = buzzer_q;

endmodule

`default_nettype wire

// File: tb/tb_bomb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bomb_game_ctrl : directed scenarios plus randomized run against a game model
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bomb_game_ctrl;

  localparam int         BLINK = 500;
  localparam int         MAXS  = 2;
  localparam logic [3:0] SAFE  = 4'b0101;

  localparam int M_IDLE = 0, M_ARMED = 1, M_DEFUSED = 2, M_BOOM = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic [3:0] wires = 4'hF;
  logic [3:0] s1 = 4'd9;
  logic [3:0] s2 = 4'd1;
  logic       start, success, wire_fault, buzzer;
  logic [3:0] state_led;
  logic [1:0] strikes;

  int total = 0;
  int bad   = 0;

  // Game model: which phase we are in, strike tally, time spent exploded.
  int         m_mode    = M_IDLE;
  int         m_strikes = 0;
  int         m_age     = 0;
  bit         m_wf      = 1'b0;
  bit         m_pbtn    = 1'b0;
  logic [3:0] m_pw      = 4'hF;

  bomb_game_ctrl #(
    .NW(4), .SAFE_MASK(SAFE), .MAX_STRIKES(MAXS), .BLINK_DIV(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .wires(wires), .s1(s1), .s2(s2),
    .start(start), .success(success), .state_led(state_led), .strikes(strikes),
    .wire_fault(wire_fault), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] model_outputs();
    bit         buz;
    logic [3:0] led;
    buz = (m_mode == M_BOOM) && (((m_age / BLINK) % 2) == 0);
    case (m_mode)
      M_ARMED:   led = 4'b0010;
      M_DEFUSED: led = 4'b0100;
      M_BOOM:    led = buz ? 4'b1000 : 4'b0000;
      default:   led = 4'b0001;
    endcase
    return {(m_mode == M_ARMED || m_mode == M_DEFUSED), (m_mode == M_DEFUSED),
            led, 2'(m_strikes), m_wf, buz};
  endfunction

  // One clock edge: the model consumes the same inputs the DUT just sampled.
  task automatic cycle();
    bit         rise;
    logic [3:0] cuts;
    @(posedge clk);
    rise = btn_start && !m_pbtn;
    cuts = m_pw & ~wires;
    if (rst) begin
      m_mode = M_IDLE; m_strikes = 0; m_wf = 1'b0; m_age = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (rise) begin
          if (wires == 4'hF) begin m_mode = M_ARMED; m_strikes = 0; m_wf = 1'b0; end
          else m_wf = 1'b1;
        end
        M_ARMED: begin
          if (s1 == 4'hF && s2 == 4'hF) begin
            m_mode = M_BOOM; m_age = 0;
          end else if ((cuts & ~SAFE) != 4'b0) begin
            m_strikes = (m_strikes < 3) ? m_strikes + 1 : 3;
            if (m_strikes >= MAXS) begin m_mode = M_BOOM; m_age = 0; end
          end else if ((wires & SAFE) == 4'b0) begin
            m_mode = M_DEFUSED;
          end
        end
        M_DEFUSED: if (rise) m_mode = M_IDLE;
        default: begin
          if (rise) m_mode = M_IDLE;
          else m_age++;
        end
      endcase
    end
    m_pbtn = btn_start;
    m_pw   = wires;
    #1;
  endtask

  task automatic arm();
    wires = 4'hF; btn_start = 1'b1; cycle(); btn_start = 1'b0; cycle();
  endtask

  task automatic disarm();
    btn_start = 1'b1; cycle(); btn_start = 1'b0; cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_start = 1'b0; wires = 4'hF; cycle(); cycle();
    total++;
    if ({state_led, start, success, strikes, wire_fault, buzzer} !== 10'b0001_0_0_00_0_0) begin
      bad++;
      $display("FAIL reset_state: got %b want %b",
               {state_led, start, success, strikes, wire_fault, buzzer}, 10'b0001000000);
    end
    rst = 1'b0; cycle();
    total++;
    if (state_led !== 4'b0001) begin
      bad++; $display("FAIL reset_release: led got %b want 0001", state_led);
    end
  endtask

  task automatic test_arm();
    wires = 4'hF; btn_start = 1'b1; cycle();
    total++;
    if ({state_led, start, strikes} !== 7'b0010_1_00) begin
      bad++; $display("FAIL arm: got %b want 0010100", {state_led, start, strikes});
    end
    btn_start = 1'b0; cycle();
    total++;
    if (state_led !== 4'b0010) begin
      bad++; $display("FAIL arm_hold: led got %b want 0010", state_led);
    end
  endtask

  task automatic test_defuse();
    wires = 4'b1110; cycle();
    total++;
    if ({state_led, success} !== 5'b0010_0) begin
      bad++; $display("FAIL defuse_first_cut: got %b want 00100", {state_led, success});
    end
    wires = 4'b1010; cycle();
    total++;
    if ({state_led, success, start, buzzer} !== 7'b0100_1_1_0) begin
      bad++; $display("FAIL defuse_done: got %b want 0100110", {state_led, success, start, buzzer});
    end
    btn_start = 1'b1; cycle();
    total++;
    if ({state_led, start, success} !== 6'b0001_0_0) begin
      bad++; $display("FAIL defuse_exit: got %b want 000100", {state_led, start, success});
    end
    btn_start = 1'b0; cycle();
  endtask

  task automatic test_strikes_blink();
    arm();
    wires = 4'b1101; cycle();
    total++;
    if ({state_led, start, strikes} !== 7'b0010_1_01) begin
      bad++; $display("FAIL strike_one: got %b want 0010101", {state_led, start, strikes});
    end
    wires = 4'b0101; cycle();
    total++;
    if ({state_led, start, success, strikes, buzzer} !== 9'b1000_0_0_10_1) begin
      bad++;
      $display("FAIL strike_explode: got %b want 100000101", {state_led, start, success, strikes, buzzer});
    end
    repeat (BLINK - 1) cycle();
    total++;
    if ({state_led, buzzer} !== 5'b1000_1) begin
      bad++; $display("FAIL blink_before_wrap: got %b want 10001", {state_led, buzzer});
    end
    cycle();
    total++;
    if ({state_led, buzzer} !== 5'b0000_0) begin
      bad++; $display("FAIL blink_first_toggle: got %b want 00000", {state_led, buzzer});
    end
    repeat (BLINK) cycle();
    total++;
    if ({state_led, buzzer} !== 5'b1000_1) begin
      bad++; $display("FAIL blink_second_toggle: got %b want 10001", {state_led, buzzer});
    end
    btn_start = 1'b1; cycle();
    total++;
    if ({state_led, buzzer, strikes} !== 7'b0001_0_10) begin
      bad++; $display("FAIL explode_exit: got %b want 0001010", {state_led, buzzer, strikes});
    end
    btn_start = 1'b0; cycle();
  endtask

  task automatic test_expiry();
    arm();
    s1 = 4'hF; s2 = 4'hF; cycle();
    total++;
    if ({state_led, start} !== 5'b1000_0) begin
      bad++; $display("FAIL expiry: got %b want 10000", {state_led, start});
    end
    s1 = 4'd3; s2 = 4'd1; disarm();
    arm();
    wires = 4'b1110; cycle();
    s1 = 4'hF; s2 = 4'hF; wires = 4'b1010; cycle();
    total++;
    if ({state_led, success, strikes} !== 7'b1000_0_00) begin
      bad++; $display("FAIL expiry_vs_defuse: got %b want 1000000", {state_led, success, strikes});
    end
    s1 = 4'd9; s2 = 4'd1; disarm();
  endtask

  task automatic test_trap_and_safe_same_cycle();
    arm();
    wires = 4'b1110; cycle();
    wires = 4'b1000; cycle();
    total++;
    if ({state_led, strikes, success} !== 7'b0010_01_0) begin
      bad++; $display("FAIL trap_with_safe: got %b want 0010010", {state_led, strikes, success});
    end
    cycle();
    total++;
    if (state_led !== 4'b0100) begin
      bad++; $display("FAIL defuse_after_trap: led got %b want 0100", state_led);
    end
    disarm();
  endtask

  task automatic test_wire_fault();
    wires = 4'b1101; btn_start = 1'b1; cycle();
    total++;
    if ({state_led, wire_fault, start} !== 6'b0001_1_0) begin
      bad++; $display("FAIL wire_fault_set: got %b want 000110", {state_led, wire_fault, start});
    end
    btn_start = 1'b0; repeat (3) cycle();
    total++;
    if (wire_fault !== 1'b1) begin
      bad++; $display("FAIL wire_fault_hold: got %b want 1", wire_fault);
    end
    wires = 4'hF; btn_start = 1'b1; cycle();
    total++;
    if ({state_led, wire_fault} !== 5'b0010_0) begin
      bad++; $display("FAIL wire_fault_clear: got %b want 00100", {state_led, wire_fault});
    end
    btn_start = 1'b0; cycle();
  endtask

  task automatic test_reset_mid_armed();
    wires = 4'b0111; cycle();
    total++;
    if (strikes !== 2'd1) begin
      bad++; $display("FAIL pre_reset_strike: got %0d want 1", strikes);
    end
    rst = 1'b1; btn_start = 1'b1; cycle();
    total++;
    if ({state_led, start, success, strikes, wire_fault, buzzer} !== 10'b0001_0_0_00_0_0) begin
      bad++;
      $display("FAIL reset_mid_armed: got %b want 0001000000",
               {state_led, start, success, strikes, wire_fault, buzzer});
    end
    rst = 1'b0; cycle();
    total++;
    if (state_led !== 4'b0001) begin
      bad++; $display("FAIL no_edge_after_reset: led got %b want 0001", state_led);
    end
    btn_start = 1'b0; cycle();
  endtask

  task automatic test_random();
    logic [9:0] want, got;
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
      if (m_mode == M_ARMED) begin
        if ($urandom_range(0, 5) == 0) wires = wires & ~(4'b0001 << $urandom_range(0, 3));
      end else if (m_mode == M_IDLE) begin
        wires = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      end
      s1 = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 9));
      s2 = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 9));
      cycle();
      want = model_outputs();
      got  = {start, success, state_led, strikes, wire_fault, buzzer};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL random_step%0d: got %b want %b", i, got, want);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arm();
    test_defuse();
    test_strikes_blink();
    test_expiry();
    test_trap_and_safe_same_cycle();
    test_wire_fault();
    test_reset_mid_armed();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
